// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and width defaults for the skid pipe register
package pipe_pkg;

   localparam int PIPE_DATA_W = 64;
   localparam int PIPE_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_slot64.sv
// rtl/pipe_slot64.sv - one payload slot: register with load enable and sync clear (clear wins)
module pipe_slot64
   import pipe_pkg::*;
#(
   parameter int W = PIPE_DATA_W + 1
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/pipe_skid_reg64.sv
// rtl/pipe_skid_reg64.sv - two-slot skid register with registered in_ready and stall counter
// Optional flush port and logic enabled by PIPE_SKID_FLUSH_EN.
module pipe_skid_reg64
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CNT_W  = PIPE_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sel,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic              flush,
`endif
   output logic [CNT_W-1:0]  stall_cnt
);

   pipe_state_t     state, state_nxt;
   logic            kill, in_fire, out_fire;
   logic            main_load, skid_load, slot_clr;
   logic [DATA_W:0] main_d, main_q, skid_q;

`ifdef PIPE_SKID_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   assign out_valid = (state != ST_EMPTY);
   assign in_fire   = in_valid && in_ready && !kill;
   assign out_fire  = out_valid && out_ready;
   assign slot_clr  = reset || kill;

   always_comb begin
      state_nxt = state;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = {in_sel, in_data};
      case (state)
         ST_EMPTY: begin
            if (in_fire) begin
               main_load = 1'b1;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (in_fire && out_fire) begin
               main_load = 1'b1;
            end else if (in_fire) begin
               skid_load = 1'b1;
               state_nxt = ST_FULL;
            end else if (out_fire) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               main_load = 1'b1;
               main_d    = skid_q;
               state_nxt = ST_BUSY;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      if (kill)
         state_nxt = ST_EMPTY;
   end

   // in_ready is a pure function of the registered next state, so it never sees out_ready combinationally
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != ST_FULL);
         if (out_valid && !out_ready && !kill && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   pipe_slot64 #(.W(DATA_W + 1)) u_main (
      .clk   (clk),
      .clear (slot_clr),
      .load  (main_load),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_slot64 #(.W(DATA_W + 1)) u_skid (
      .clk   (clk),
      .clear (slot_clr),
      .load  (skid_load),
      .d     ({in_sel, in_data}),
      .q     (skid_q)
   );

   assign {out_sel, out_data} = main_q;

endmodule

// File: tb/tb_pipe_skid_reg64.sv
// tb/tb_pipe_skid_reg64.sv - directed self-checking bench for pipe_skid_reg64 (default and CNT_W=4 instances)
module tb_pipe_skid_reg64;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        out_ready;
`ifdef PIPE_SKID_FLUSH_EN
   logic        flush;
`endif

   logic        a_in_ready, a_out_sel, a_out_valid;
   logic [63:0] a_out_data;
   logic [15:0] a_stall_cnt;
   logic        b_in_ready, b_out_sel, b_out_valid;
   logic [63:0] b_out_data;
   logic [3:0]  b_stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_skid_reg64 u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (a_in_ready),
      .out_data  (a_out_data),
      .out_sel   (a_out_sel),
      .out_valid (a_out_valid),
      .out_ready (out_ready),
`ifdef PIPE_SKID_FLUSH_EN
      .flush     (flush),
`endif
      .stall_cnt (a_stall_cnt)
   );

   pipe_skid_reg64 #(.CNT_W(4)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (b_in_ready),
      .out_data  (b_out_data),
      .out_sel   (b_out_sel),
      .out_valid (b_out_valid),
      .out_ready (out_ready),
`ifdef PIPE_SKID_FLUSH_EN
      .flush     (flush),
`endif
      .stall_cnt (b_stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset    = 1'b1;
      in_valid = 1'b0;
      step();
      reset    = 1'b0;
      step();
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = '0;
      in_sel    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
      flush     = 1'b0;
`endif

      // reset held two cycles
      step();
      step();
      check_eq("rst_out_valid", a_out_valid, 0);
      check_eq("rst_in_ready", a_in_ready, 0);
      check_eq("rst_out_data", a_out_data, 0);
      check_eq("rst_out_sel", a_out_sel, 0);
      check_eq("rst_stall_cnt", a_stall_cnt, 0);
      reset = 1'b0;
      step();
      check_eq("post_rst_in_ready", a_in_ready, 1);

      // single transfer, one-cycle latency
      in_data = 64'h1; in_sel = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step();
      check_eq("first_out_valid", a_out_valid, 1);
      check_eq("first_out_data", a_out_data, 64'h1);
      check_eq("first_out_sel", a_out_sel, 1);
      in_valid = 1'b0; in_sel = 1'b0; in_data = 64'hdead;
      step();
      check_eq("first_drained", a_out_valid, 0);

      // back-to-back stream 0x10..0x17
      for (int i = 0; i < 8; i++) begin
         in_data  = 64'h10 + 64'(i);
         in_sel   = i[0];
         in_valid = 1'b1;
         step();
         check_eq($sformatf("stream_data_%0d", i), a_out_data, 64'h10 + 64'(i));
         check_eq($sformatf("stream_sel_%0d", i), a_out_sel, 64'(i[0]));
         check_eq($sformatf("stream_in_ready_%0d", i), a_in_ready, 1);
      end
      in_valid = 1'b0;
      step();
      check_eq("stream_drained", a_out_valid, 0);
      check_eq("stream_stall_cnt", a_stall_cnt, 0);

      // back-pressure into FULL, then release
      reset_pulse();
      out_ready = 1'b0;
      in_data = 64'hA; in_valid = 1'b1;
      step();
      check_eq("bp_a_loaded", a_out_data, 64'hA);
      in_data = 64'hB;
      step();
      check_eq("bp_full_in_ready", a_in_ready, 0);
      in_valid = 1'b0; in_data = 64'h0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq($sformatf("bp_hold_data_%0d", i), a_out_data, 64'hA);
      end
      check_eq("bp_stall_cnt_held", a_stall_cnt, 4);
      out_ready = 1'b1;
      #1;
      check_eq("bp_release_first", a_out_data, 64'hA);
      step();
      check_eq("bp_release_second", a_out_data, 64'hB);
      check_eq("bp_release_valid", a_out_valid, 1);
      check_eq("bp_release_in_ready", a_in_ready, 1);
      step();
      check_eq("bp_drained", a_out_valid, 0);
      check_eq("bp_stall_cnt_final", a_stall_cnt, 4);

      // stall counter saturation in 4-bit instance
      reset_pulse();
      out_ready = 1'b0;
      in_data = 64'h5; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check_eq("sat_wide_cnt", a_stall_cnt, 20);
      check_eq("sat_narrow_cnt", b_stall_cnt, 4'hF);
      check_eq("sat_narrow_data", b_out_data, 64'h5);

      // reset while FULL
      in_data = 64'hC; in_valid = 1'b1;
      step();
      check_eq("rstfull_in_ready", a_in_ready, 0);
      reset = 1'b1;
      step();
      check_eq("rstfull_out_valid", a_out_valid, 0);
      check_eq("rstfull_in_ready_low", a_in_ready, 0);
      check_eq("rstfull_out_data", a_out_data, 0);
      check_eq("rstfull_stall_cnt", a_stall_cnt, 0);
      reset = 1'b0; in_valid = 1'b0;
      step();
      check_eq("rstfull_release_in_ready", a_in_ready, 1);
      check_eq("rstfull_release_out_valid", a_out_valid, 0);

`ifdef PIPE_SKID_FLUSH_EN
      // flush while FULL with a concurrent input
      reset_pulse();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'h21;
      step();
      in_data = 64'h22;
      step();
      check_eq("flush_pre_in_ready", a_in_ready, 0);
      flush = 1'b1; in_data = 64'h23;
      step();
      check_eq("flush_out_valid", a_out_valid, 0);
      check_eq("flush_stall_cnt", a_stall_cnt, 1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      check_eq("flush_nothing_emerges", a_out_valid, 0);
      in_valid = 1'b1; in_data = 64'h24;
      step();
      check_eq("flush_next_data", a_out_data, 64'h24);
      in_valid = 1'b0;
      step();
      check_eq("flush_drained", a_out_valid, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
